// File: rtl/countdown_if.sv
// countdown_if: request/status bundle between the front panel, the BCD
// countdown datapath and the countdown_ctrl sequencer.
//   set_valid/set_minute : load request, packed BCD minutes {tens,units}
//   start/pause_tog/stop : one-cycle button requests
//   cur_minute/second    : live BCD datapath outputs (for zero detect)
//   tick/load/load_minute: datapath decrement enable and load strobe
//   running/paused/alarm : state indications; set_err : rejected set pulse
// master = environment (panel + datapath), slave = controller.
interface countdown_if;
    logic       set_valid;
    logic [7:0] set_minute;
    logic       start;
    logic       pause_tog;
    logic       stop;
    logic [7:0] cur_minute;
    logic [7:0] cur_second;
    logic       tick;
    logic       load;
    logic [7:0] load_minute;
    logic       running;
    logic       paused;
    logic       alarm;
    logic       set_err;

    modport master (
        output set_valid, set_minute, start, pause_tog, stop, cur_minute, cur_second,
        input  tick, load, load_minute, running, paused, alarm, set_err
    );

    modport slave (
        input  set_valid, set_minute, start, pause_tog, stop, cur_minute, cur_second,
        output tick, load, load_minute, running, paused, alarm, set_err
    );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: sequencer for the BCD minute/second countdown datapath.
// Divides the system clock into a 1 Hz tick enable, issues validated BCD
// load strobes, watches the datapath for 00:00 and runs the
// IDLE/ARMED/RUN/PAUSE/EXPIRED state machine behind the front-panel buttons.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : countdown_if.slave (requests in, tick/load/status out)
//
// Parameters: TICK_DIV (clocks per second, >=2), DIV_W (prescaler width,
// holds TICK_DIV-1), ALARM_SECS (alarm duration in seconds, 1..255).
//
// Optional feature macro: COUNTDOWN_REPEAT_EN -- when defined, an alarm that
// times out reloads the retained minute value and restarts the countdown.
module countdown_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int DIV_W      = 26,
    parameter int ALARM_SECS = 10
) (
    input logic        clk,
    input logic        rst_n,
    countdown_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] presc, presc_n;
    logic [7:0]       acnt, acnt_n;
    logic             tick_q, tick_n;
    logic             load_q, load_n;
    logic             err_q, err_n;
    logic [7:0]       lm_q, lm_n;
    logic             running_q, paused_q, alarm_q;

    logic set_ok, is_zero, zero_hit, wrap;

    assign set_ok  = (bus.set_minute[7:4] <= 4'd9) && (bus.set_minute[3:0] <= 4'd9);
    assign is_zero = (bus.cur_minute == 8'h00) && (bus.cur_second == 8'h00);
    assign wrap    = (presc == DIV_W'(TICK_DIV - 1));

`ifdef COUNTDOWN_REPEAT_EN
    // On a repeat restart the datapath still shows 00:00 while the reload
    // strobe is in flight; ignore zero for that one cycle.
    assign zero_hit = is_zero && !load_q;
`else
    assign zero_hit = is_zero;
`endif

    always_comb begin
        state_n = state;
        presc_n = presc;
        acnt_n  = acnt;
        tick_n  = 1'b0;
        load_n  = 1'b0;
        err_n   = 1'b0;
        lm_n    = lm_q;
        // Request chain: each branch only fires when the request applies to
        // the current state, so an inapplicable request falls through.
        if (bus.stop) begin
            state_n = S_IDLE;
            presc_n = '0;
            acnt_n  = '0;
        end else if (bus.set_valid && (state == S_IDLE || state == S_ARMED)) begin
            if (set_ok) begin
                load_n  = 1'b1;
                lm_n    = bus.set_minute;
                state_n = S_ARMED;
            end else begin
                err_n = 1'b1;
            end
        end else if (bus.start && (state == S_ARMED || state == S_PAUSE)) begin
            if (state == S_ARMED) presc_n = '0;   // resume keeps the partial second
            state_n = S_RUN;
        end else if (bus.pause_tog && (state == S_RUN || state == S_PAUSE || state == S_EXPIRED)) begin
            case (state)
                S_RUN:   state_n = S_PAUSE;
                S_PAUSE: state_n = S_RUN;
                default: begin                      // alarm acknowledge
                    state_n = S_IDLE;
                    presc_n = '0;
                    acnt_n  = '0;
                end
            endcase
        end else begin
            case (state)
                S_RUN: begin
                    if (zero_hit) begin
                        // Start the alarm period on a second boundary so it
                        // lasts exactly ALARM_SECS * TICK_DIV cycles.
                        state_n = S_EXPIRED;
                        presc_n = '0;
                        acnt_n  = '0;
                    end else if (wrap) begin
                        presc_n = '0;
                        tick_n  = 1'b1;
                    end else begin
                        presc_n = presc + DIV_W'(1);
                    end
                end
                S_EXPIRED: begin
                    if (wrap) begin
                        presc_n = '0;
                        if (acnt == 8'(ALARM_SECS - 1)) begin
                            acnt_n = '0;
`ifdef COUNTDOWN_REPEAT_EN
                            load_n  = 1'b1;
                            state_n = S_RUN;
`else
                            state_n = S_IDLE;
`endif
                        end else begin
                            acnt_n = acnt + 8'd1;
                        end
                    end else begin
                        presc_n = presc + DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            presc     <= '0;
            acnt      <= '0;
            tick_q    <= 1'b0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            lm_q      <= 8'h00;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            acnt      <= acnt_n;
            tick_q    <= tick_n;
            load_q    <= load_n;
            err_q     <= err_n;
            lm_q      <= lm_n;
            running_q <= (state_n == S_RUN);
            paused_q  <= (state_n == S_PAUSE);
            alarm_q   <= (state_n == S_EXPIRED);
        end
    end

    assign bus.tick        = tick_q;
    assign bus.load        = load_q;
    assign bus.load_minute = lm_q;
    assign bus.set_err     = err_q;
    assign bus.running     = running_q;
    assign bus.paused      = paused_q;
    assign bus.alarm       = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl (TICK_DIV=4, ALARM_SECS=2).
// A BCD datapath model closes the loop; a behavioural reference tracks the
// mode, progress within the current second and time spent alarming, and is
// compared against the DUT on every falling edge. Directed scenarios add
// hand-computed expectations, followed by randomized button traffic.
module tb_countdown_ctrl;
    localparam int TD = 4;
    localparam int AS = 2;

    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_if bus();

    countdown_ctrl #(.TICK_DIV(TD), .DIV_W(3), .ALARM_SECS(AS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- datapath model ----------------
    logic [7:0] dp_min, dp_sec;
    assign bus.cur_minute = dp_min;
    assign bus.cur_second = dp_sec;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_min <= 8'h00;
            dp_sec <= 8'h00;
        end else if (bus.load) begin
            dp_min <= bus.load_minute;
            dp_sec <= 8'h00;
        end else if (bus.tick && !(dp_min == 8'h00 && dp_sec == 8'h00)) begin
            if (dp_sec == 8'h00) begin
                dp_sec <= 8'h59;
                dp_min <= bcd_dec(dp_min);
            end else begin
                dp_sec <= bcd_dec(dp_sec);
            end
        end
    end

    // ---------------- reference model ----------------
    int         m_mode, m_phase, m_age;
    logic [7:0] m_lm;
    logic       e_tick, e_load, e_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_phase <= 0; m_age <= 0; m_lm <= 8'h00;
            e_tick <= 1'b0; e_load <= 1'b0; e_err <= 1'b0;
        end else begin : model_step
            int md, ph, ag;
            logic tk, ld, er;
            logic [7:0] lm;
            md = m_mode; ph = m_phase; ag = m_age; lm = m_lm;
            tk = 1'b0; ld = 1'b0; er = 1'b0;
            if (bus.stop) begin
                md = M_IDLE; ph = 0; ag = 0;
            end else if (bus.set_valid && (md == M_IDLE || md == M_ARMED)) begin
                if (bus.set_minute[7:4] < 10 && bus.set_minute[3:0] < 10) begin
                    ld = 1'b1; lm = bus.set_minute; md = M_ARMED;
                end else begin
                    er = 1'b1;
                end
            end else if (bus.start && md == M_ARMED) begin
                md = M_RUN; ph = 0;
            end else if (bus.start && md == M_PAUSE) begin
                md = M_RUN;
            end else if (bus.pause_tog && md == M_RUN) begin
                md = M_PAUSE;
            end else if (bus.pause_tog && md == M_PAUSE) begin
                md = M_RUN;
            end else if (bus.pause_tog && md == M_EXP) begin
                md = M_IDLE; ph = 0; ag = 0;
            end else if (md == M_RUN) begin
`ifdef COUNTDOWN_REPEAT_EN
                if (dp_min == 8'h00 && dp_sec == 8'h00 && !e_load) begin
`else
                if (dp_min == 8'h00 && dp_sec == 8'h00) begin
`endif
                    md = M_EXP; ph = 0; ag = 0;
                end else begin
                    ph = (ph + 1) % TD;
                    tk = (ph == 0);
                end
            end else if (md == M_EXP) begin
                ag = ag + 1;
                if (ag == AS * TD) begin
                    ph = 0; ag = 0;
`ifdef COUNTDOWN_REPEAT_EN
                    md = M_RUN; ld = 1'b1;
`else
                    md = M_IDLE;
`endif
                end
            end
            m_mode <= md; m_phase <= ph; m_age <= ag; m_lm <= lm;
            e_tick <= tk; e_load <= ld; e_err <= er;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [13:0] got_v, exp_v;
    assign got_v = {bus.tick, bus.load, bus.load_minute, bus.running, bus.paused, bus.alarm, bus.set_err};
    assign exp_v = {e_tick, e_load, m_lm, m_mode == M_RUN, m_mode == M_PAUSE, m_mode == M_EXP, e_err};

    always @(negedge clk) begin
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL outputs t=%0t {tick,load,lm,run,pause,alarm,err} got %b expected %b",
                     $time, got_v, exp_v);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of requests (set up after a falling edge, sampled at
    // the next rising edge), then return on the following falling edge.
    task automatic step(input logic sv, input logic [7:0] sm, input logic st,
                        input logic pt, input logic sp);
        bus.set_valid = sv; bus.set_minute = sm; bus.start = st;
        bus.pause_tog = pt; bus.stop = sp;
        @(negedge clk);
        bus.set_valid = 1'b0; bus.set_minute = 8'h00; bus.start = 1'b0;
        bus.pause_tog = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int ticks, t1, t2, n, bad;
        bus.set_valid = 1'b0; bus.set_minute = 8'h00; bus.start = 1'b0;
        bus.pause_tog = 1'b0; bus.stop = 1'b0;
        idle(3);
        chk("reset_outputs", int'(got_v), 0);
        rst_n = 1'b1;
        idle(2);

        // invalid set
        step(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0);
        chk("bad_set_err", bus.set_err, 1);
        chk("bad_set_noload", bus.load, 0);
        idle(1);
        chk("bad_set_err_1cyc", bus.set_err, 0);
        chk("bad_set_lm", bus.load_minute, 0);

        // valid set 01 and full minute countdown
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("set_load", bus.load, 1);
        chk("set_lm", bus.load_minute, 8'h01);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("start_running", bus.running, 1);
        ticks = 0; t1 = -1; t2 = -1;
        for (int i = 0; i < 400; i++) begin
            if (bus.alarm) break;
            if (bus.tick) begin
                ticks++;
                if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
            end
            @(negedge clk);
        end
        chk("alarm_rose", bus.alarm, 1);
        chk("ticks_before_alarm", ticks, 60);
        chk("first_tick_cycle", t1, 4);
        chk("second_tick_cycle", t2, 8);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("stop_alarm", bus.alarm, 0);

        // pause mid-second with two cycles of progress
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("paused", bus.paused, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tick) bad++;
            @(negedge clk);
        end
        chk("tick_in_pause", bad, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("resumed", bus.running, 1);
        idle(1);
        chk("resume_tick_early", bus.tick, 0);
        idle(1);
        chk("resume_tick", bus.tick, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // zero start: immediate expiry, alarm for AS seconds
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("zero_run", bus.running, 1);
        idle(1);
        chk("zero_alarm", bus.alarm, 1);
        n = 0; bad = 0;
        while (bus.alarm && n < 100) begin
            if (bus.tick) bad++;
            n++;
            @(negedge clk);
        end
        chk("alarm_cycles", n, AS * TD);
        chk("alarm_ticks", bad, 0);
`ifdef COUNTDOWN_REPEAT_EN
        chk("repeat_run", bus.running, 1);
        chk("repeat_load", bus.load, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`else
        chk("timeout_idle", bus.running, 0);
`endif

        // priority: stop beats set and start
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
        chk("prio_idle", bus.running, 0);
        chk("prio_noload", bus.load, 0);
        chk("prio_lm", bus.load_minute, 8'h03);

        // async reset mid-run
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(5);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", int'(got_v), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic sv, st, pt, sp;
            logic [7:0] sm;
            sv = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 9) == 0);
            pt = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) sm = 8'($urandom_range(0, 255));
            else                           sm = {4'h0, 4'($urandom_range(0, 1))};
            step(sv, sm, st, pt, sp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencer for the BCD minute/second countdown datapath.
- Runs on the fast system clock and generates the 1 Hz tick enable for the datapath.
- Issues load strobes with a validated BCD minute value and watches the datapath outputs for 00:00.
- Runs the start/pause/stop/alarm state machine that sits between front-panel buttons and the countdown.

Parameters:
- TICK_DIV, 50000000, system clock cycles per countdown second (>=2)
- DIV_W, 26, prescaler width; must hold TICK_DIV-1
- ALARM_SECS, 10, seconds alarm stays asserted after expiry (1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- set_valid  input  1  one-cycle request to load set_minute
- set_minute  input  8  requested minutes, packed BCD {tens,units}
- start  input  1  one-cycle start/resume request
- pause_tog  input  1  one-cycle pause/resume toggle
- stop  input  1  one-cycle abort/acknowledge
- cur_minute  input  8  datapath minute, BCD
- cur_second  input  8  datapath second, BCD
- tick  output  1  one-cycle datapath decrement enable
- load  output  1  one-cycle datapath load strobe
- load_minute  output  8  value presented with load; held until next accepted set
- running  output  1  high in RUN
- paused  output  1  high in PAUSE
- alarm  output  1  high in EXPIRED
- set_err  output  1  one-cycle pulse when set_valid is rejected

Behaviour:
- Reset (rst_n low, async): state IDLE, prescaler 0, alarm counter 0, all outputs 0, load_minute 8'h00.
- States: IDLE, ARMED, RUN, PAUSE, EXPIRED. running, paused and alarm are registered decodes of state.
- Request priority in one cycle: stop > set_valid > start > pause_tog. Only the highest-priority applicable request acts; the rest are dropped.
- stop: any state -> IDLE next cycle. Clears prescaler and alarm. Does not touch the datapath.
- set_valid: accepted only in IDLE or ARMED, ignored elsewhere.
  - Valid means each nibble <= 9.
  - Valid: load=1 for the next cycle only, load_minute<=set_minute, state -> ARMED.
  - Invalid: set_err=1 for the next cycle only; state and load_minute unchanged.
  - The datapath sees load one cycle after set_valid.
- start:
  - ARMED -> RUN, prescaler cleared to 0.
  - PAUSE -> RUN, prescaler kept.
  - Ignored in IDLE, RUN and EXPIRED (in EXPIRED, start does nothing).
- pause_tog: RUN -> PAUSE; PAUSE -> RUN. Prescaler frozen in PAUSE, so resume completes the partial second.
- RUN:
  - Prescaler increments each cycle and wraps at TICK_DIV-1.
  - In the wrap cycle, tick=1 for the next cycle, unless zero is detected.
  - First tick arrives TICK_DIV cycles after entry from ARMED.
- Zero detect: in RUN, cur_minute==8'h00 and cur_second==8'h00 -> EXPIRED next cycle. Any tick in that cycle is suppressed.
  - Starting from a loaded 00 minutes expires immediately, 1 cycle after RUN entry, with no tick.
  - After the tick that takes the datapath to 00:00, expiry follows once the datapath outputs reflect 00:00.
- EXPIRED:
  - alarm=1. Prescaler runs, but tick is never output.
  - Alarm counter counts prescaler wraps; after ALARM_SECS wraps -> IDLE.
  - stop or pause_tog acknowledges -> IDLE next cycle.
- A load issued while the datapath is mid-count is the caller's concern. The controller never issues load outside IDLE/ARMED, except as described under COUNTDOWN_REPEAT_EN.
- tick and load are never high in the same cycle.

Optional Feature:
- Macro: COUNTDOWN_REPEAT_EN.
- Defined: when the EXPIRED alarm period ends by timeout (not by stop or pause_tog), the controller pulses load with the retained load_minute, then enters RUN with the prescaler cleared. load and RUN entry happen in the same cycle. This repeats indefinitely until stop.
- Not defined: the alarm timeout returns to IDLE as described above, with no extra logic.

Test Plan:
- Invalid set: TICK_DIV=4, set_valid with set_minute=8'h1A in IDLE -> set_err pulse 1 cycle, no load, state IDLE.
- Valid set and run: set 8'h01, then start -> load pulse with 8'h01 one cycle after set_valid. tick pulses every 4 cycles; with a datapath model, 60 ticks occur before alarm rises.
- Pause/resume: pause_tog mid-second (prescaler=2) for 10 cycles, then pause_tog -> no tick during pause. Next tick 2 cycles after resume.
- Zero start: set 8'h00, start -> RUN 1 cycle, then alarm=1, no tick ever. Alarm drops after ALARM_SECS*4 cycles (IDLE).
- Priority and reset: stop+set_valid+start in one cycle during RUN -> IDLE, no load. rst_n low mid-RUN -> all outputs 0 immediately.
- Repeat (COUNTDOWN_REPEAT_EN): set 8'h00 with ALARM_SECS=2 -> after 8 alarm cycles, load pulse with 8'h00 and re-entry to RUN and EXPIRED. Without the macro -> IDLE.
